// File: rtl/wave_unwarp_reader_if.sv
// ---------------------------------------------------------------------------
// wave_unwarp_reader_if
//
// Purpose: bundles the raster request side, the frame-buffer read port and
// the pixel output side of wave_unwarp_reader into one interface.
//
// Signals:
//   frame_start_in  one-cycle pulse marking the start of a frame
//   anim_en_in      enables phase advance at frame start
//   data_valid_in   pixel request qualifier
//   hcount_in       [10:0] output-raster column
//   vcount_in       [9:0]  output-raster row
//   bram_addr_out   [16:0] frame-buffer read address
//   bram_data_in    [6:0]  frame-buffer read data (2-cycle read latency)
//   data_valid_out  pixel_out qualifier
//   hcount_out      [10:0] hcount_in delayed to line up with pixel_out
//   vcount_out      [9:0]  vcount_in delayed to line up with pixel_out
//   pixel_out       [6:0]  unwarped pixel
//
// Modports:
//   slave   - the reader itself
//   master  - whatever drives the requests and owns the frame buffer
// ---------------------------------------------------------------------------
interface wave_unwarp_reader_if;
  logic        frame_start_in;
  logic        anim_en_in;
  logic        data_valid_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [16:0] bram_addr_out;
  logic [6:0]  bram_data_in;
  logic        data_valid_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic [6:0]  pixel_out;

  modport slave (
    input  frame_start_in,
    input  anim_en_in,
    input  data_valid_in,
    input  hcount_in,
    input  vcount_in,
    input  bram_data_in,
    output bram_addr_out,
    output data_valid_out,
    output hcount_out,
    output vcount_out,
    output pixel_out
  );

  modport master (
    output frame_start_in,
    output anim_en_in,
    output data_valid_in,
    output hcount_in,
    output vcount_in,
    output bram_data_in,
    input  bram_addr_out,
    input  data_valid_out,
    input  hcount_out,
    input  vcount_out,
    input  pixel_out
  );
endinterface

// File: rtl/wave_unwarp_reader.sv
// ---------------------------------------------------------------------------
// wave_unwarp_reader
//
// Purpose: reads a frame buffer with a vertical "wave" distortion removed.
// For every requested output pixel (hcount, vcount) a per-row offset is
// derived from a cubic of the phase-shifted row, the source row is wrapped
// into the frame, and the frame-buffer address src*WIDTH + hcount[7:0] is
// issued. The returned pixel is emitted five cycles after the request, with
// the raster counters delayed to match. The phase can advance every frame
// to animate the wave.
//
// Ports:
//   clk_in   single clock, all state on the rising edge
//   rst_in   asynchronous, active-low reset
//   bus      wave_unwarp_reader_if.slave (requests, BRAM port, pixel output)
//
// Parameters:
//   HEIGHT      rows per frame buffer, also the row wrap modulus
//   WIDTH       pixels per row, also the address row stride
//   PHASE_STEP  phase advance per animated frame (must be < HEIGHT)
//
// Timing (request sampled at edge k):
//   k    : offset terms registered
//   k+1  : cubic product / offset registered
//   k+2  : wrapped source row -> bram_addr_out
//   k+4  : BRAM data present on bram_data_in
//   k+5  : pixel_out / data_valid_out / hcount_out / vcount_out
// ---------------------------------------------------------------------------
module wave_unwarp_reader #(
  parameter int HEIGHT     = 320,
  parameter int WIDTH      = 240,
  parameter int PHASE_STEP = 4
) (
  input logic                 clk_in,
  input logic                 rst_in,
  wave_unwarp_reader_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [10:0]        HEIGHT_U = 11'(HEIGHT);
  localparam logic [10:0]        WIDTH_U  = 11'(WIDTH);
  localparam logic [10:0]        STEP_U   = 11'(PHASE_STEP);
  localparam logic signed [15:0] HEIGHT_S = 16'(HEIGHT);
  localparam logic [16:0]        STRIDE   = 17'(WIDTH);

  // Number of metadata stages between the sample edge and the output edge.
  localparam int DEPTH = 5;

  // Per-pixel side information that travels alongside the datapath.
  typedef struct packed {
    logic        valid;
    logic        oob;
    logic [10:0] hcount;
    logic [9:0]  vcount;
  } meta_t;

  // -------------------------------------------------------------------------
  // Control state and phase
  // -------------------------------------------------------------------------
  logic [0:0]  state_reg;
  logic [9:0]  phase_reg;
  logic [10:0] phase_sum;
  logic [9:0]  phase_next;

  always_comb begin
    phase_sum  = {1'b0, phase_reg} + STEP_U;
    phase_next = (phase_sum >= HEIGHT_U) ? 10'(phase_sum - HEIGHT_U)
                                         : phase_sum[9:0];
  end

  // The first frame_start leaves IDLE; the phase advances on that same pulse
  // when animation is enabled, exactly as it does on later frame starts.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg <= IDLE;
      phase_reg <= '0;
    end else if (bus.frame_start_in) begin
      state_reg <= RUN;
      if (bus.anim_en_in) begin
        phase_reg <= phase_next;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: sample request, shifted row and the three offset terms.
  // The terms read phase_reg before any update on this edge, so a request
  // coincident with frame_start uses the old phase.
  // -------------------------------------------------------------------------
  logic               req_valid;
  logic               req_oob;
  logic [10:0]        v_sum;
  logic [10:0]        v_mod;
  logic signed [11:0] v_s;
  logic signed [11:0] top_next;
  logic signed [11:0] mid_next;
  logic signed [11:0] bot_next;
  meta_t              meta_in;

  always_comb begin
    req_valid = bus.data_valid_in && (state_reg == RUN);
    req_oob   = ({1'b0, bus.vcount_in} >= HEIGHT_U) || (bus.hcount_in >= WIDTH_U);

    // vcount_in and phase are both below HEIGHT for in-range requests, so a
    // single conditional subtract is a full modulo.
    v_sum = {1'b0, bus.vcount_in} + {1'b0, phase_reg};
    v_mod = (v_sum >= HEIGHT_U) ? (v_sum - HEIGHT_U) : v_sum;
    v_s   = $signed({1'b0, v_mod});

    // Arithmetic shifts give floor division for the negative terms.
    top_next = (v_s - 12'sd320) >>> 4;
    mid_next = (v_s - 12'sd120) >>> 3;
    bot_next = v_s >>> 4;

    meta_in        = '0;
    meta_in.valid  = req_valid;
    meta_in.oob    = req_oob;
    meta_in.hcount = bus.hcount_in;
    meta_in.vcount = bus.vcount_in;
  end

  logic signed [11:0] top_reg;
  logic signed [11:0] mid_reg;
  logic signed [11:0] bot_reg;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      top_reg <= '0;
      mid_reg <= '0;
      bot_reg <= '0;
    end else begin
      top_reg <= top_next;
      mid_reg <= mid_next;
      bot_reg <= bot_next;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: cubic product and offset. The product magnitude stays below
  // 2^14 for HEIGHT=320, but 32-bit arithmetic keeps any HEIGHT safe.
  // -------------------------------------------------------------------------
  logic signed [31:0] top_ext;
  logic signed [31:0] mid_ext;
  logic signed [31:0] bot_ext;
  logic signed [31:0] prod;
  logic signed [15:0] off_next;
  logic signed [15:0] off_reg;

  always_comb begin
    top_ext  = {{20{top_reg[11]}}, top_reg};
    mid_ext  = {{20{mid_reg[11]}}, mid_reg};
    bot_ext  = {{20{bot_reg[11]}}, bot_reg};
    prod     = top_ext * mid_ext * bot_ext;
    off_next = 16'(prod >>> 5);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      off_reg <= '0;
    end else begin
      off_reg <= off_next;
    end
  end

  // -------------------------------------------------------------------------
  // Metadata shift register: meta_reg[i] holds the request sampled i-1 edges
  // earlier, so meta_reg[2] lines up with off_reg and meta_reg[DEPTH] lines
  // up with the BRAM data for that request.
  // -------------------------------------------------------------------------
  meta_t meta_reg [1:DEPTH];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 1; i <= DEPTH; i++) begin
        meta_reg[i] <= '0;
      end
    end else begin
      meta_reg[1] <= meta_in;
      for (int i = 2; i <= DEPTH; i++) begin
        meta_reg[i] <= meta_reg[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3: source row (from the raw vcount, not the shifted row), one
  // wrap correction, then the frame-buffer address.
  // -------------------------------------------------------------------------
  logic signed [15:0] src_raw;
  logic signed [15:0] src_wrap;
  logic [16:0]        addr_next;
  logic [16:0]        addr_reg;

  always_comb begin
    src_raw = $signed({6'd0, meta_reg[2].vcount}) - off_reg;
    if (src_raw >= HEIGHT_S) begin
      src_wrap = src_raw - HEIGHT_S;
    end else if (src_raw < 16'sd0) begin
      src_wrap = src_raw + HEIGHT_S;
    end else begin
      src_wrap = src_raw;
    end
    addr_next = 17'(src_wrap) * STRIDE + 17'(meta_reg[2].hcount[7:0]);
  end

  // The address only moves for valid in-range requests; idle cycles and
  // out-of-frame requests leave the last address on the bus.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      addr_reg <= '0;
    end else if (meta_reg[2].valid && !meta_reg[2].oob) begin
      addr_reg <= addr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Output stage: capture BRAM data together with the delayed counters.
  // Out-of-frame requests still produce a valid pixel, forced to zero.
  // -------------------------------------------------------------------------
  logic        valid_out_reg;
  logic [6:0]  pixel_reg;
  logic [10:0] hcount_out_reg;
  logic [9:0]  vcount_out_reg;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_out_reg  <= 1'b0;
      pixel_reg      <= '0;
      hcount_out_reg <= '0;
      vcount_out_reg <= '0;
    end else begin
      valid_out_reg <= meta_reg[DEPTH].valid;
      if (meta_reg[DEPTH].valid) begin
        pixel_reg      <= meta_reg[DEPTH].oob ? 7'd0 : bus.bram_data_in;
        hcount_out_reg <= meta_reg[DEPTH].hcount;
        vcount_out_reg <= meta_reg[DEPTH].vcount;
      end
    end
  end

  assign bus.bram_addr_out  = addr_reg;
  assign bus.data_valid_out = valid_out_reg;
  assign bus.pixel_out      = pixel_reg;
  assign bus.hcount_out     = hcount_out_reg;
  assign bus.vcount_out     = vcount_out_reg;

endmodule

// File: tb/tb_wave_unwarp_reader.sv
// ---------------------------------------------------------------------------
// tb_wave_unwarp_reader
//
// Directed bench for wave_unwarp_reader. A 2-cycle-latency BRAM model filled
// with random bytes serves the read port. Expected addresses for the directed
// vectors are hand-computed; the long stream uses a small reference function.
// ---------------------------------------------------------------------------
module tb_wave_unwarp_reader;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wave_unwarp_reader_if bus ();
  wave_unwarp_reader_if bus6 ();

  wave_unwarp_reader dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  // Second instance with a step of 6 so phase 318 is reachable from 0.
  wave_unwarp_reader #(.PHASE_STEP(6)) dut6 (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus6)
  );

  // Frame-buffer model: address registered, then data registered.
  logic [6:0] mem [0:131071];
  logic [6:0] q1_reg;
  logic [6:0] q2_reg;

  always @(posedge clk) begin
    q1_reg <= mem[bus.bram_addr_out];
    q2_reg <= q1_reg;
  end

  assign bus.bram_data_in  = q2_reg;
  assign bus6.bram_data_in = 7'd0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic fs, input logic anim, input logic dv, input int v, input int h);
    bus.frame_start_in = fs;
    bus.anim_en_in     = anim;
    bus.data_valid_in  = dv;
    bus.vcount_in      = 10'(v);
    bus.hcount_in      = 11'(h);
  endtask

  task automatic pulse(input logic anim);
    drive(1'b1, anim, 1'b0, 0, 0);
    tick();
    drive(1'b0, anim, 1'b0, 0, 0);
    tick();
  endtask

  // One isolated request: address after edge k+2, still invalid after k+4,
  // pixel and counters after k+5.
  task automatic single(input string tag, input logic fs, input logic anim,
                        input int v, input int h, input int exp_addr, input logic oob);
    logic [6:0] exp_pix;
    exp_pix = oob ? 7'd0 : mem[exp_addr];
    drive(fs, anim, 1'b1, v, h);
    tick();
    drive(1'b0, anim, 1'b0, 0, 0);
    tick();
    tick();
    check({tag, "_addr"}, 32'(bus.bram_addr_out), 32'(exp_addr));
    tick();
    tick();
    check({tag, "_early"}, 32'(bus.data_valid_out), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(bus.data_valid_out), 32'd1);
    check({tag, "_pixel"}, 32'(bus.pixel_out), 32'(exp_pix));
    check({tag, "_hcount"}, 32'(bus.hcount_out), 32'(h));
    check({tag, "_vcount"}, 32'(bus.vcount_out), 32'(v));
    $display("txn %s v=%0d h=%0d addr=%0d pixel=%0d", tag, v, h,
             bus.bram_addr_out, bus.pixel_out);
  endtask

  function automatic int ref_addr(input int vc, input int hc, input int ph);
    int v, top, mid, bot, off, src;
    v   = (vc + ph) % 320;
    top = (v - 320) >>> 4;
    mid = (v - 120) >>> 3;
    bot = v >>> 4;
    off = (top * mid * bot) >>> 5;
    src = vc - off;
    if (src >= 320) src = src - 320;
    else if (src < 0) src = src + 320;
    return src * 240 + (hc % 256);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 7'($urandom);
    bus6.frame_start_in = 1'b0;
    bus6.anim_en_in     = 1'b0;
    bus6.data_valid_in  = 1'b0;
    bus6.hcount_in      = '0;
    bus6.vcount_in      = '0;
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_addr", 32'(bus.bram_addr_out), 32'd0);
    check("rst_valid", 32'(bus.data_valid_out), 32'd0);
    check("rst_pixel", 32'(bus.pixel_out), 32'd0);
    check("rst_hcount", 32'(bus.hcount_out), 32'd0);
    check("rst_vcount", 32'(bus.vcount_out), 32'd0);
    check("rst_phase", 32'(dut.phase_reg), 32'd0);
    rst_n = 1'b1;
    tick();

    // Requests in IDLE are ignored
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b1, 200, 3);
      tick();
      check("idle_valid", 32'(bus.data_valid_out), 32'd0);
    end
    check("idle_addr", 32'(bus.bram_addr_out), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    tick();

    // Enter RUN without animation
    pulse(1'b0);
    check("run_phase", 32'(dut.phase_reg), 32'd0);

    single("v200h3", 1'b0, 1'b0, 200, 3, 55203, 1'b0);
    single("v300h7", 1'b0, 1'b0, 300, 7, 1207, 1'b0);
    single("v100h0", 1'b0, 1'b0, 100, 0, 22320, 1'b0);
    single("v319h239", 1'b0, 1'b0, 319, 239, 3599, 1'b0);
    single("oob_v330", 1'b0, 1'b0, 330, 5, 3599, 1'b1);
    single("oob_h250", 1'b0, 1'b0, 10, 250, 3599, 1'b1);

    // 320 back-to-back requests, phase 0
    for (int j = 0; j < 325; j++) begin
      if (j < 320) drive(1'b0, 1'b0, 1'b1, j, (j * 7) % 240);
      else drive(1'b0, 1'b0, 1'b0, 0, 0);
      tick();
      if (j < 5) begin
        check("stream_pre", 32'(bus.data_valid_out), 32'd0);
      end else begin
        int idx, hi;
        logic [28:0] exp_w, got_w;
        idx   = j - 5;
        hi    = (idx * 7) % 240;
        exp_w = {1'b1, 10'(idx), 11'(hi), mem[ref_addr(idx, hi, 0)]};
        got_w = {bus.data_valid_out, bus.vcount_out, bus.hcount_out, bus.pixel_out};
        check("stream", 32'(got_w), 32'(exp_w));
        $display("stream v=%0d h=%0d pixel=%0d", bus.vcount_out, bus.hcount_out, bus.pixel_out);
      end
    end
    tick();
    check("stream_tail", 32'(bus.data_valid_out), 32'd0);

    // Reset in the middle of a stream
    for (int j = 0; j < 10; j++) begin
      drive(1'b0, 1'b0, 1'b1, j + 40, j + 1);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.data_valid_out), 32'd0);
    check("mid_rst_addr", 32'(bus.bram_addr_out), 32'd0);
    check("mid_rst_pixel", 32'(bus.pixel_out), 32'd0);
    check("mid_rst_hcount", 32'(bus.hcount_out), 32'd0);
    check("mid_rst_vcount", 32'(bus.vcount_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      drive(1'b0, 1'b0, 1'b1, 50, 2);
      tick();
      check("post_rst_valid", 32'(bus.data_valid_out), 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    tick();

    // Phase animation: IDLE->RUN pulse plus two more
    for (int i = 0; i < 3; i++) pulse(1'b1);
    check("phase_12", 32'(dut.phase_reg), 32'd12);
    single("neg_wrap", 1'b0, 1'b0, 5, 1, 76321, 1'b0);
    single("coincident", 1'b1, 1'b1, 200, 3, 55683, 1'b0);
    check("phase_16", 32'(dut.phase_reg), 32'd16);
    for (int i = 0; i < 75; i++) pulse(1'b1);
    check("phase_316", 32'(dut.phase_reg), 32'd316);
    pulse(1'b1);
    check("phase_wrap0", 32'(dut.phase_reg), 32'd0);

    // Step-6 instance: reach 318, then wrap past HEIGHT
    bus6.anim_en_in = 1'b1;
    for (int i = 0; i < 53; i++) begin
      bus6.frame_start_in = 1'b1;
      tick();
      bus6.frame_start_in = 1'b0;
      tick();
    end
    check("phase6_318", 32'(dut6.phase_reg), 32'd318);
    bus6.frame_start_in = 1'b1;
    tick();
    bus6.frame_start_in = 1'b0;
    tick();
    check("phase6_wrap", 32'(dut6.phase_reg), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
